// File: rtl/match_scoreboard_if.sv
// Bundle between the tug-of-war playfield and the match scoreboard.
// The playfield side (master) raises the round-victory strobes.
// The scoreboard side (slave) returns the score, the display digits,
// the field-reset request and the match result.
interface match_scoreboard_if;
    logic       victory_left_i;
    logic       victory_right_i;
    logic       field_reset_o;
    logic [2:0] score_left_o;
    logic [2:0] score_right_o;
    logic [6:0] hex_left_o;
    logic [6:0] hex_right_o;
    logic       match_over_o;
    logic       winner_right_o;

    modport master (
        output victory_left_i,
        output victory_right_i,
        input  field_reset_o,
        input  score_left_o,
        input  score_right_o,
        input  hex_left_o,
        input  hex_right_o,
        input  match_over_o,
        input  winner_right_o
    );

    modport slave (
        input  victory_left_i,
        input  victory_right_i,
        output field_reset_o,
        output score_left_o,
        output score_right_o,
        output hex_left_o,
        output hex_right_o,
        output match_over_o,
        output winner_right_o
    );
endinterface

// File: rtl/match_scoreboard.sv
// Match scoreboard for the tug-of-war game.
// Counts rounds won by each player, holds the playfield in reset for a
// fixed pause after every round, and latches the winner once a player
// reaches WIN_SCORE. Scores are shown as active-low seven-segment digits.
module match_scoreboard #(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic               clkSelect,
    input  logic               reset,
    match_scoreboard_if.slave  bus
);

    localparam int              CNT_W      = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [2:0]      WIN_VAL    = 3'(WIN_SCORE);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        PAUSE = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t           state_q,       state_d;
    logic [2:0]       scoreLeft_q,   scoreLeft_d;
    logic [2:0]       scoreRight_q,  scoreRight_d;
    logic             fieldReset_q,  fieldReset_d;
    logic             matchOver_q,   matchOver_d;
    logic             winnerRight_q, winnerRight_d;
    logic [CNT_W-1:0] pauseCnt_q,    pauseCnt_d;

    logic [2:0]       leftInc;
    logic [2:0]       rightInc;

    // Active-low segment pattern (g..a) for one score digit; anything
    // outside the legal score range blanks the display.
    function automatic logic [6:0] hexDecode(input logic [2:0] value);
        logic [6:0] seg;
        case (value)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            3'd7:    seg = 7'b1111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Saturating increments so a score can never wrap past WIN_SCORE.
    always_comb begin
        leftInc  = (scoreLeft_q  >= WIN_VAL) ? WIN_VAL : scoreLeft_q  + 3'd1;
        rightInc = (scoreRight_q >= WIN_VAL) ? WIN_VAL : scoreRight_q + 3'd1;
    end

    // Next-state logic: award rounds in PLAY, time the pause, freeze in OVER.
    always_comb begin
        state_d       = state_q;
        scoreLeft_d   = scoreLeft_q;
        scoreRight_d  = scoreRight_q;
        fieldReset_d  = fieldReset_q;
        matchOver_d   = matchOver_q;
        winnerRight_d = winnerRight_q;
        pauseCnt_d    = pauseCnt_q;

        case (state_q)
            PLAY: begin
                fieldReset_d = 1'b0;
                if (bus.victory_left_i && bus.victory_right_i) begin
                    state_d      = PAUSE;
                    fieldReset_d = 1'b1;
                    pauseCnt_d   = PAUSE_LOAD;
                end else if (bus.victory_left_i) begin
                    scoreLeft_d  = leftInc;
                    fieldReset_d = 1'b1;
                    pauseCnt_d   = PAUSE_LOAD;
                    if (leftInc == WIN_VAL) begin
                        state_d       = OVER;
                        matchOver_d   = 1'b1;
                        winnerRight_d = 1'b0;
                    end else begin
                        state_d = PAUSE;
                    end
                end else if (bus.victory_right_i) begin
                    scoreRight_d = rightInc;
                    fieldReset_d = 1'b1;
                    pauseCnt_d   = PAUSE_LOAD;
                    if (rightInc == WIN_VAL) begin
                        state_d       = OVER;
                        matchOver_d   = 1'b1;
                        winnerRight_d = 1'b1;
                    end else begin
                        state_d = PAUSE;
                    end
                end
            end

            PAUSE: begin
                fieldReset_d = 1'b1;
                if (pauseCnt_q == '0) begin
                    state_d      = PLAY;
                    fieldReset_d = 1'b0;
                end else begin
                    pauseCnt_d = pauseCnt_q - 1'b1;
                end
            end

            OVER: begin
                fieldReset_d = 1'b1;
            end

            default: begin
                state_d      = PLAY;
                fieldReset_d = 1'b0;
            end
        endcase
    end

    // State register; reset wins over any strobe sampled on the same edge.
    always_ff @(posedge clkSelect) begin
        if (reset) begin
            state_q       <= PLAY;
            scoreLeft_q   <= 3'd0;
            scoreRight_q  <= 3'd0;
            fieldReset_q  <= 1'b0;
            matchOver_q   <= 1'b0;
            winnerRight_q <= 1'b0;
            pauseCnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            scoreLeft_q   <= scoreLeft_d;
            scoreRight_q  <= scoreRight_d;
            fieldReset_q  <= fieldReset_d;
            matchOver_q   <= matchOver_d;
            winnerRight_q <= winnerRight_d;
            pauseCnt_q    <= pauseCnt_d;
        end
    end

    // Outputs come straight from registers; the digits are decoded from them.
    always_comb begin
        bus.field_reset_o  = fieldReset_q;
        bus.score_left_o   = scoreLeft_q;
        bus.score_right_o  = scoreRight_q;
        bus.match_over_o   = matchOver_q;
        bus.winner_right_o = winnerRight_q;
        bus.hex_left_o     = hexDecode(scoreLeft_q);
        bus.hex_right_o    = hexDecode(scoreRight_q);
    end

endmodule

// File: tb/tb_match_scoreboard.sv
// Directed testbench for match_scoreboard (WIN_SCORE=7, PAUSE_CYCLES=4).
// Each scenario task drives the strobes and checks outputs one time unit
// after the rising edge.
module tb_match_scoreboard;

    logic clkSelect = 1'b0;
    logic reset     = 1'b1;
    int   assertCount = 0;
    int   failCount   = 0;

    logic [6:0] hexTab [8];

    match_scoreboard_if bus();

    match_scoreboard #(
        .WIN_SCORE    (7),
        .PAUSE_CYCLES (4)
    ) dut (
        .clkSelect (clkSelect),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clkSelect = ~clkSelect;

    // Advance one clock and settle just past the edge.
    task automatic tick;
        @(posedge clkSelect);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.victory_left_i  = 1'b0;
        bus.victory_right_i = 1'b0;
        tick();
        tick();
        assertCount++;
        if (bus.score_left_o !== 3'd0 || bus.score_right_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL reset_scores: got %0d/%0d want 0/0", bus.score_left_o, bus.score_right_o);
        end
        assertCount++;
        if (bus.hex_left_o !== 7'b1000000 || bus.hex_right_o !== 7'b1000000) begin
            failCount++;
            $display("[TB] FAIL reset_hex: got %b/%b want 1000000/1000000", bus.hex_left_o, bus.hex_right_o);
        end
        assertCount++;
        if (bus.field_reset_o !== 1'b0 || bus.match_over_o !== 1'b0 || bus.winner_right_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_flags: got fr=%b mo=%b wr=%b want 0 0 0", bus.field_reset_o, bus.match_over_o, bus.winner_right_o);
        end
        reset = 1'b0;
        tick();
        assertCount++;
        if (bus.field_reset_o !== 1'b0 || bus.score_left_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL idle_play: got fr=%b sl=%0d want 0 0", bus.field_reset_o, bus.score_left_o);
        end
    endtask

    task automatic test_right_round;
        bus.victory_right_i = 1'b1;
        tick();
        bus.victory_right_i = 1'b0;
        assertCount++;
        if (bus.score_right_o !== 3'd1 || bus.score_left_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL right_round_score: got %0d/%0d want 0/1", bus.score_left_o, bus.score_right_o);
        end
        assertCount++;
        if (bus.hex_right_o !== 7'b1111001) begin
            failCount++;
            $display("[TB] FAIL right_round_hex: got %b want 1111001", bus.hex_right_o);
        end
        assertCount++;
        if (bus.field_reset_o !== 1'b1 || bus.match_over_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL right_round_fr1: got fr=%b mo=%b want 1 0", bus.field_reset_o, bus.match_over_o);
        end
        for (int c = 2; c <= 4; c++) begin
            tick();
            assertCount++;
            if (bus.field_reset_o !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL right_round_pause_c%0d: got fr=%b want 1", c, bus.field_reset_o);
            end
        end
        tick();
        assertCount++;
        if (bus.field_reset_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL right_round_release: got fr=%b want 0", bus.field_reset_o);
        end
        tick();
        assertCount++;
        if (bus.field_reset_o !== 1'b0 || bus.score_right_o !== 3'd1) begin
            failCount++;
            $display("[TB] FAIL right_round_hold: got fr=%b sr=%0d want 0 1", bus.field_reset_o, bus.score_right_o);
        end
    endtask

    task automatic test_draw;
        bus.victory_left_i  = 1'b1;
        bus.victory_right_i = 1'b1;
        tick();
        bus.victory_left_i  = 1'b0;
        bus.victory_right_i = 1'b0;
        assertCount++;
        if (bus.score_left_o !== 3'd0 || bus.score_right_o !== 3'd1) begin
            failCount++;
            $display("[TB] FAIL draw_scores: got %0d/%0d want 0/1", bus.score_left_o, bus.score_right_o);
        end
        assertCount++;
        if (bus.field_reset_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL draw_fr1: got fr=%b want 1", bus.field_reset_o);
        end
        for (int c = 2; c <= 4; c++) begin
            tick();
            assertCount++;
            if (bus.field_reset_o !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL draw_pause_c%0d: got fr=%b want 1", c, bus.field_reset_o);
            end
        end
        tick();
        assertCount++;
        if (bus.field_reset_o !== 1'b0 || bus.score_left_o !== 3'd0 || bus.score_right_o !== 3'd1) begin
            failCount++;
            $display("[TB] FAIL draw_release: got fr=%b sl=%0d sr=%0d want 0 0 1", bus.field_reset_o, bus.score_left_o, bus.score_right_o);
        end
    endtask

    task automatic test_pause_ignore;
        bus.victory_right_i = 1'b1;
        tick();
        bus.victory_right_i = 1'b0;
        assertCount++;
        if (bus.score_right_o !== 3'd2 || bus.hex_right_o !== 7'b0100100) begin
            failCount++;
            $display("[TB] FAIL pause_ignore_right: got sr=%0d hex=%b want 2 0100100", bus.score_right_o, bus.hex_right_o);
        end
        tick();
        bus.victory_left_i = 1'b1;
        tick();
        tick();
        bus.victory_left_i = 1'b0;
        assertCount++;
        if (bus.field_reset_o !== 1'b1 || bus.score_left_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL pause_ignore_mid: got fr=%b sl=%0d want 1 0", bus.field_reset_o, bus.score_left_o);
        end
        tick();
        assertCount++;
        if (bus.field_reset_o !== 1'b0 || bus.score_left_o !== 3'd0 || bus.hex_left_o !== 7'b1000000) begin
            failCount++;
            $display("[TB] FAIL pause_ignore_end: got fr=%b sl=%0d hex=%b want 0 0 1000000", bus.field_reset_o, bus.score_left_o, bus.hex_left_o);
        end
    endtask

    task automatic test_left_match;
        for (int r = 1; r <= 7; r++) begin
            bus.victory_left_i = 1'b1;
            tick();
            bus.victory_left_i = 1'b0;
            assertCount++;
            if (bus.score_left_o !== 3'(r) || bus.hex_left_o !== hexTab[r]) begin
                failCount++;
                $display("[TB] FAIL left_match_r%0d: got sl=%0d hex=%b want %0d %b", r, bus.score_left_o, bus.hex_left_o, r, hexTab[r]);
            end
            if (r < 7) begin
                assertCount++;
                if (bus.match_over_o !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL left_match_early_r%0d: got mo=%b want 0", r, bus.match_over_o);
                end
                for (int c = 0; c < 4; c++) tick();
            end
        end
        assertCount++;
        if (bus.match_over_o !== 1'b1 || bus.winner_right_o !== 1'b0 || bus.field_reset_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL left_match_over: got mo=%b wr=%b fr=%b want 1 0 1", bus.match_over_o, bus.winner_right_o, bus.field_reset_o);
        end
        bus.victory_left_i  = 1'b1;
        bus.victory_right_i = 1'b1;
        tick();
        bus.victory_left_i  = 1'b0;
        tick();
        bus.victory_right_i = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        assertCount++;
        if (bus.score_left_o !== 3'd7 || bus.score_right_o !== 3'd2 || bus.field_reset_o !== 1'b1 ||
            bus.match_over_o !== 1'b1 || bus.winner_right_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL left_match_frozen: got sl=%0d sr=%0d fr=%b mo=%b wr=%b want 7 2 1 1 0",
                     bus.score_left_o, bus.score_right_o, bus.field_reset_o, bus.match_over_o, bus.winner_right_o);
        end
    endtask

    task automatic test_reset_in_over;
        reset = 1'b1;
        bus.victory_left_i = 1'b1;
        tick();
        reset = 1'b0;
        bus.victory_left_i = 1'b0;
        assertCount++;
        if (bus.score_left_o !== 3'd0 || bus.score_right_o !== 3'd0 || bus.field_reset_o !== 1'b0 ||
            bus.match_over_o !== 1'b0 || bus.winner_right_o !== 1'b0 ||
            bus.hex_left_o !== 7'b1000000 || bus.hex_right_o !== 7'b1000000) begin
            failCount++;
            $display("[TB] FAIL reset_in_over: got sl=%0d sr=%0d fr=%b mo=%b wr=%b want 0 0 0 0 0",
                     bus.score_left_o, bus.score_right_o, bus.field_reset_o, bus.match_over_o, bus.winner_right_o);
        end
        tick();
        assertCount++;
        if (bus.field_reset_o !== 1'b0 || bus.score_left_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL reset_in_over_play: got fr=%b sl=%0d want 0 0", bus.field_reset_o, bus.score_left_o);
        end
    endtask

    task automatic test_reset_mid_pause;
        bus.victory_left_i = 1'b1;
        tick();
        bus.victory_left_i = 1'b0;
        tick();
        assertCount++;
        if (bus.score_left_o !== 3'd1 || bus.field_reset_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL mid_pause_setup: got sl=%0d fr=%b want 1 1", bus.score_left_o, bus.field_reset_o);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        assertCount++;
        if (bus.score_left_o !== 3'd0 || bus.field_reset_o !== 1'b0 || bus.hex_left_o !== 7'b1000000) begin
            failCount++;
            $display("[TB] FAIL mid_pause_reset: got sl=%0d fr=%b hex=%b want 0 0 1000000", bus.score_left_o, bus.field_reset_o, bus.hex_left_o);
        end
        tick();
        assertCount++;
        if (bus.field_reset_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mid_pause_play: got fr=%b want 0", bus.field_reset_o);
        end
    endtask

    task automatic test_right_match;
        for (int r = 1; r <= 7; r++) begin
            bus.victory_right_i = 1'b1;
            tick();
            bus.victory_right_i = 1'b0;
            if (r < 7) begin
                for (int c = 0; c < 4; c++) tick();
            end
        end
        assertCount++;
        if (bus.score_right_o !== 3'd7 || bus.hex_right_o !== 7'b1111000 || bus.score_left_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL right_match_score: got sl=%0d sr=%0d hex=%b want 0 7 1111000", bus.score_left_o, bus.score_right_o, bus.hex_right_o);
        end
        assertCount++;
        if (bus.match_over_o !== 1'b1 || bus.winner_right_o !== 1'b1 || bus.field_reset_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL right_match_over: got mo=%b wr=%b fr=%b want 1 1 1", bus.match_over_o, bus.winner_right_o, bus.field_reset_o);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        assertCount++;
        if (bus.winner_right_o !== 1'b0 || bus.match_over_o !== 1'b0 || bus.score_right_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL right_match_reset: got wr=%b mo=%b sr=%0d want 0 0 0", bus.winner_right_o, bus.match_over_o, bus.score_right_o);
        end
    endtask

    initial begin
        hexTab[0] = 7'b1000000;
        hexTab[1] = 7'b1111001;
        hexTab[2] = 7'b0100100;
        hexTab[3] = 7'b0110000;
        hexTab[4] = 7'b0011001;
        hexTab[5] = 7'b0010010;
        hexTab[6] = 7'b0000010;
        hexTab[7] = 7'b1111000;
        bus.victory_left_i  = 1'b0;
        bus.victory_right_i = 1'b0;

        $display("[TB] starting match_scoreboard tests");
        test_reset();
        test_right_round();
        test_draw();
        test_pause_ignore();
        test_left_match();
        test_reset_in_over();
        test_reset_mid_pause();
        test_right_match();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
